// File: rtl/rast_perf_counter.sv
// Rasterizer performance counter.
// Counts cycles, accepted triangles, sample tests, sample hits and stall cycles over a
// start/stop window, followed by a drain phase that collects hits still in flight.
// All counters saturate; any clamp sets the sticky sat flag.
// Optional feature macro: RAST_PERF_HIST_EN adds a per-popcount hit histogram.
module rast_perf_counter #(
   parameter int unsigned SAMPS      = 4,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned PIPE_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_RnnnnH,
   input  logic             stop_RnnnnH,
   input  logic             validTri_R10H,
   input  logic             halt_RnnnnL,
   input  logic             validSamp_R16H,
   input  logic [SAMPS-1:0] hit_valid_R18H,
   output logic [1:0]       state_RnnnnU,
   output logic             done_RnnnnH,
   output logic [CNT_W-1:0] cycle_cnt_RnnnnU,
   output logic [CNT_W-1:0] tri_cnt_RnnnnU,
   output logic [CNT_W-1:0] samp_cnt_RnnnnU,
   output logic [CNT_W-1:0] hit_cnt_RnnnnU,
   output logic [CNT_W-1:0] stall_cnt_RnnnnU,
   output logic             sat_RnnnnH
`ifdef RAST_PERF_HIST_EN
   ,
   output logic [CNT_W-1:0] hist_RnnnnU [SAMPS+1]
`endif
);

   localparam int unsigned PcW = $clog2(SAMPS + 1);
   localparam int unsigned DrW = (PIPE_DEPTH > 0) ? $clog2(PIPE_DEPTH + 1) : 1;

   typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDrain = 2'd2, StDone = 2'd3} state_e;

   state_e           state_q, state_d;
   logic [DrW-1:0]   drain_q, drain_d;
   logic             clear;
   logic             run, act;
   logic [PcW-1:0]   pop;
   logic             hist_ovf;

   logic [CNT_W-1:0] cycle_q, cycle_d, tri_cnt_q, tri_cnt_d, samp_q, samp_d;
   logic [CNT_W-1:0] hit_q, hit_d, stall_q, stall_d;
   logic             sat_q, sat_d;
   logic [CNT_W:0]   cycle_s, tri_s, samp_s, hit_s, stall_s;

   // Top bit of the result flags an overflow; the sum is then clamped to all ones.
   function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[CNT_W]) return {1'b1, {CNT_W{1'b1}}};
      return s;
   endfunction

   assign run = (state_q == StRun);
   assign act = (state_q == StRun) || (state_q == StDrain);

   // Number of lanes hitting at R18 this cycle.
   always_comb begin
      pop = '0;
      for (int i = 0; i < SAMPS; i++) pop = pop + PcW'(hit_valid_R18H[i]);
   end

   // Window FSM next state; start from IDLE/DONE also clears every counter.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      clear   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_RnnnnH) begin
               state_d = StRun;
               clear   = 1'b1;
            end
         end
         StRun: begin
            // stop wins over a simultaneous start
            if (stop_RnnnnH) begin
               if (PIPE_DEPTH == 0) begin
                  state_d = StDone;
               end else begin
                  state_d = StDrain;
                  drain_d = DrW'(PIPE_DEPTH);
               end
            end
         end
         StDrain: begin
            drain_d = drain_q - DrW'(1);
            if (drain_q <= DrW'(1)) begin
               state_d = StDone;
               drain_d = '0;
            end
         end
         StDone: begin
            if (start_RnnnnH) begin
               state_d = StRun;
               clear   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Saturating counter updates and sticky saturation flag.
   always_comb begin
      cycle_d   = cycle_q;
      tri_cnt_d = tri_cnt_q;
      samp_d    = samp_q;
      hit_d     = hit_q;
      stall_d   = stall_q;
      sat_d     = sat_q;
      cycle_s   = sat_add(cycle_q, CNT_W'(1));
      tri_s     = sat_add(tri_cnt_q, CNT_W'(1));
      samp_s    = sat_add(samp_q, CNT_W'(SAMPS));
      hit_s     = sat_add(hit_q, CNT_W'(pop));
      stall_s   = sat_add(stall_q, CNT_W'(1));
      if (clear) begin
         cycle_d   = '0;
         tri_cnt_d = '0;
         samp_d    = '0;
         hit_d     = '0;
         stall_d   = '0;
         sat_d     = 1'b0;
      end else begin
         if (run) begin
            cycle_d = cycle_s[CNT_W-1:0];
            sat_d   = sat_d | cycle_s[CNT_W];
            if (validTri_R10H && halt_RnnnnL) begin
               tri_cnt_d = tri_s[CNT_W-1:0];
               sat_d     = sat_d | tri_s[CNT_W];
            end
            if (validSamp_R16H && halt_RnnnnL) begin
               samp_d = samp_s[CNT_W-1:0];
               sat_d  = sat_d | samp_s[CNT_W];
            end
            if (!halt_RnnnnL) begin
               stall_d = stall_s[CNT_W-1:0];
               sat_d   = sat_d | stall_s[CNT_W];
            end
         end
         // Hits keep arriving during drain and are counted regardless of halt.
         if (act) begin
            hit_d = hit_s[CNT_W-1:0];
            sat_d = sat_d | hit_s[CNT_W];
         end
         sat_d = sat_d | hist_ovf;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         drain_q   <= '0;
         cycle_q   <= '0;
         tri_cnt_q <= '0;
         samp_q    <= '0;
         hit_q     <= '0;
         stall_q   <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         cycle_q   <= cycle_d;
         tri_cnt_q <= tri_cnt_d;
         samp_q    <= samp_d;
         hit_q     <= hit_d;
         stall_q   <= stall_d;
         sat_q     <= sat_d;
      end
   end

`ifdef RAST_PERF_HIST_EN
   logic             samp_r18;
   logic [CNT_W-1:0] hist_q [SAMPS+1];
   logic [CNT_W-1:0] hist_d [SAMPS+1];
   logic [CNT_W:0]   hist_s;

   if (PIPE_DEPTH == 0) begin : g_nodly
      assign samp_r18 = validSamp_R16H;
   end else begin : g_dly
      logic [PIPE_DEPTH-1:0] dly_q;
      // Aligns validSamp with the R18 hit vector it produced.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) dly_q <= '0;
         else      dly_q <= (dly_q << 1) | PIPE_DEPTH'(validSamp_R16H);
      end
      assign samp_r18 = dly_q[PIPE_DEPTH-1];
   end

   // Bin the popcount of every active R18 cycle.
   always_comb begin
      hist_d   = hist_q;
      hist_ovf = 1'b0;
      hist_s   = '0;
      if (clear) begin
         for (int k = 0; k <= SAMPS; k++) hist_d[k] = '0;
      end else if (act && (samp_r18 || (hit_valid_R18H != '0))) begin
         hist_s       = sat_add(hist_q[pop], CNT_W'(1));
         hist_d[pop]  = hist_s[CNT_W-1:0];
         hist_ovf     = hist_s[CNT_W];
      end
   end

   // Histogram bin registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k <= SAMPS; k++) hist_q[k] <= '0;
      end else begin
         for (int k = 0; k <= SAMPS; k++) hist_q[k] <= hist_d[k];
      end
   end

   assign hist_RnnnnU = hist_q;
`else
   assign hist_ovf = 1'b0;
`endif

   assign state_RnnnnU     = state_q;
   assign done_RnnnnH      = (state_q == StDone);
   assign cycle_cnt_RnnnnU = cycle_q;
   assign tri_cnt_RnnnnU   = tri_cnt_q;
   assign samp_cnt_RnnnnU  = samp_q;
   assign hit_cnt_RnnnnU   = hit_q;
   assign stall_cnt_RnnnnU = stall_q;
   assign sat_RnnnnH       = sat_q;

endmodule

// File: tb/tb_rast_perf_counter.sv
// Directed bench for rast_perf_counter: one default instance (SAMPS 4, CNT_W 32,
// PIPE_DEPTH 4) and one narrow instance (CNT_W 4, PIPE_DEPTH 0) for saturation.
module tb_rast_perf_counter;

   logic       clk, rst;
   logic       start, stop, vtri, halt, vsamp;
   logic [3:0] hit;
   logic       start2, stop2, vsamp2;

   logic [1:0]  state;
   logic        done, sat;
   logic [31:0] cycle_cnt, tri_cnt, samp_cnt, hit_cnt, stall_cnt;

   logic [1:0]  state2;
   logic        done2, sat2;
   logic [3:0]  cycle2, tri2, samp2, hit2, stall2;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   rast_perf_counter #(.SAMPS(4), .CNT_W(32), .PIPE_DEPTH(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .start_RnnnnH     (start),
      .stop_RnnnnH      (stop),
      .validTri_R10H    (vtri),
      .halt_RnnnnL      (halt),
      .validSamp_R16H   (vsamp),
      .hit_valid_R18H   (hit),
      .state_RnnnnU     (state),
      .done_RnnnnH      (done),
      .cycle_cnt_RnnnnU (cycle_cnt),
      .tri_cnt_RnnnnU   (tri_cnt),
      .samp_cnt_RnnnnU  (samp_cnt),
      .hit_cnt_RnnnnU   (hit_cnt),
      .stall_cnt_RnnnnU (stall_cnt),
      .sat_RnnnnH       (sat)
   );

   rast_perf_counter #(.SAMPS(4), .CNT_W(4), .PIPE_DEPTH(0)) dut_small (
      .clk              (clk),
      .rst              (rst),
      .start_RnnnnH     (start2),
      .stop_RnnnnH      (stop2),
      .validTri_R10H    (vtri),
      .halt_RnnnnL      (halt),
      .validSamp_R16H   (vsamp2),
      .hit_valid_R18H   (hit),
      .state_RnnnnU     (state2),
      .done_RnnnnH      (done2),
      .cycle_cnt_RnnnnU (cycle2),
      .tri_cnt_RnnnnU   (tri2),
      .samp_cnt_RnnnnU  (samp2),
      .hit_cnt_RnnnnU   (hit2),
      .stall_cnt_RnnnnU (stall2),
      .sat_RnnnnH       (sat2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; start = 0; stop = 0; vtri = 0; halt = 1; vsamp = 0; hit = '0;
      start2 = 0; stop2 = 0; vsamp2 = 0;
      #12;
      chk("reset_state", 32'(state), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_cycle", cycle_cnt, 0);
      chk("reset_sat", 32'(sat), 0);
      rst = 1'b1;
      tick();

      // Async reset in the middle of a window
      start = 1; tick(); start = 0;
      chk("t1_state_run", 32'(state), 1);
      vtri = 1;
      repeat (7) tick();
      vtri = 0;
      chk("t1_tri7", tri_cnt, 7);
      rst = 1'b0;
      #1;
      chk("t1_async_state", 32'(state), 0);
      chk("t1_async_tri", tri_cnt, 0);
      chk("t1_async_cycle", cycle_cnt, 0);
      #2 rst = 1'b1;
      tick();

      // Basic window with drain
      start = 1; tick(); start = 0;
      vtri = 1;
      repeat (10) tick();
      stop = 1; tick(); stop = 0; vtri = 0;
      chk("t2_state_drain", 32'(state), 2);
      repeat (3) tick();
      chk("t2_still_drain", 32'(done), 0);
      tick();
      chk("t2_done", 32'(done), 1);
      chk("t2_state_done", 32'(state), 3);
      chk("t2_cycle", cycle_cnt, 11);
      chk("t2_tri", tri_cnt, 11);
      chk("t2_stall", stall_cnt, 0);

      // Stalls suppress triangle acceptance
      start = 1; tick(); start = 0;
      chk("t3_cleared", cycle_cnt, 0);
      vtri = 1;
      for (int i = 0; i < 19; i++) begin
         halt = (i >= 3 && i < 8) ? 1'b0 : 1'b1;
         tick();
      end
      halt = 1; stop = 1; tick(); stop = 0; vtri = 0;
      repeat (4) tick();
      chk("t3_done", 32'(done), 1);
      chk("t3_tri", tri_cnt, 15);
      chk("t3_stall", stall_cnt, 5);
      chk("t3_cycle", cycle_cnt, 20);

      // Hits in RUN and DRAIN, none after DONE
      start = 1; tick(); start = 0;
      hit = 4'b1011; vsamp = 1;
      repeat (2) tick();
      vsamp = 0;
      tick();
      hit = '0; stop = 1; tick(); stop = 0;
      hit = 4'b1111;
      repeat (2) tick();
      hit = '0;
      repeat (2) tick();
      chk("t4_done", 32'(done), 1);
      chk("t4_hit", hit_cnt, 17);
      chk("t4_samp", samp_cnt, 8);
      hit = 4'b1111;
      repeat (3) tick();
      hit = '0;
      chk("t4_hit_hold", hit_cnt, 17);

      // start/stop priority
      start = 1; stop = 1; tick(); stop = 0; start = 0;
      chk("t6_done_start_run", 32'(state), 1);
      chk("t6_done_start_hit0", hit_cnt, 0);
      chk("t6_done_start_cycle0", cycle_cnt, 0);
      start = 1; stop = 1; tick(); stop = 0; start = 0;
      chk("t6_run_both_drain", 32'(state), 2);
      start = 1; tick(); start = 0;
      chk("t6_drain_ignores_start", 32'(state), 2);
      rst = 1'b0; #1; rst = 1'b1;
      stop = 1; tick(); stop = 0;
      chk("t6_idle_ignores_stop", 32'(state), 0);
      start = 1; stop = 1; tick(); stop = 0; start = 0;
      chk("t6_idle_both_run", 32'(state), 1);

      // Saturation on the narrow instance, PIPE_DEPTH 0
      halt = 1;
      start2 = 1; tick(); start2 = 0;
      vsamp2 = 1;
      repeat (20) tick();
      vsamp2 = 0;
      chk("t5_samp_sat", 32'(samp2), 15);
      chk("t5_cycle_sat", 32'(cycle2), 15);
      chk("t5_sat", 32'(sat2), 1);
      stop2 = 1; tick(); stop2 = 0;
      chk("t5_pd0_done", 32'(state2), 3);
      chk("t5_pd0_done_flag", 32'(done2), 1);
      start2 = 1; tick(); start2 = 0;
      chk("t5_sat_cleared", 32'(sat2), 0);
      chk("t5_samp_cleared", 32'(samp2), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
